// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared types, constants and helpers for the servo sweep controller
//
// Contents:
//   servo_state_t  per-channel state (OFF, SWEEP, HOMING)
//   PWM_FREQ_HZ    servo frame rate
//   calc_div       prescaler ratio so that 2^n phase steps span one frame
package servo_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        SWEEP  = 2'd1,
        HOMING = 2'd2
    } servo_state_t;

    localparam int PWM_FREQ_HZ = 50;

    function automatic int calc_div(input int sys_freq_mhz, input int n);
        return (sys_freq_mhz * 1000000) / (PWM_FREQ_HZ * (1 << n));
    endfunction

endpackage

// File: rtl/servo_sweep_ch.sv
// rtl/servo_sweep_ch.sv - one servo channel: sweep/home FSM, working duty, shadow duty and PWM comparator
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   start_stop     pulse: OFF<->SWEEP, HOMING->OFF
//   home           pulse: enter HOMING (ignored while homing)
//   rot_toggle     pulse: invert sweep direction
//   rot_en         level: allows step ticks to move the duty
//   step_tick      shared sweep step strobe
//   frame_load     shared strobe on the edge where the phase wraps to 0
//   phase          shared PWM phase
//   duty           working duty
//   busy           high in SWEEP or HOMING
//   pwm            registered PWM output
module servo_sweep_ch
    import servo_pkg::*;
#(
    parameter int N        = 12,
    parameter int DUTY_MIN = 113,
    parameter int DUTY_MAX = 521,
    parameter int DUTY_CTR = 317
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_stop,
    input  logic         home,
    input  logic         rot_toggle,
    input  logic         rot_en,
    input  logic         step_tick,
    input  logic         frame_load,
    input  logic [N-1:0] phase,
    output logic [N-1:0] duty,
    output logic         busy,
    output logic         pwm
);

    localparam logic [N-1:0] D_MIN = N'(DUTY_MIN);
    localparam logic [N-1:0] D_MAX = N'(DUTY_MAX);
    localparam logic [N-1:0] D_CTR = N'(DUTY_CTR);

    servo_state_t state_q, state_d;
    logic [N-1:0] duty_q, duty_d;
    logic [N-1:0] shadow_q, shadow_d;
    logic         dir_q, dir_d;
    logic         pwm_q, pwm_d;
    logic [N-1:0] duty_inc, duty_dec;

    assign duty_inc = duty_q + N'(1);
    assign duty_dec = duty_q - N'(1);

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        dir_d    = dir_q;
        shadow_d = frame_load ? duty_q : shadow_q;
        pwm_d    = (phase < shadow_q);

        // Only the highest-priority event of the cycle is acted on.
        if (start_stop) begin
            state_d = (state_q == OFF) ? SWEEP : OFF;
        end else if (home) begin
            if (state_q != HOMING) state_d = HOMING;
        end else if (rot_toggle) begin
            dir_d = ~dir_q;
        end else if (step_tick && rot_en) begin
            case (state_q)
                SWEEP: begin
                    if (dir_q) begin
                        // At (or past) the left limit: clamp and turn round.
                        if (duty_q >= D_MAX) begin
                            duty_d = D_MAX;
                            dir_d  = 1'b0;
                        end else begin
                            duty_d = duty_inc;
                            if (duty_inc == D_MAX) dir_d = 1'b0;
                        end
                    end else begin
                        if (duty_q <= D_MIN) begin
                            duty_d = D_MIN;
                            dir_d  = 1'b1;
                        end else begin
                            duty_d = duty_dec;
                            if (duty_dec == D_MIN) dir_d = 1'b1;
                        end
                    end
                end
                HOMING: begin
                    // Direction is implied by which side of centre we are on,
                    // so dir is only restored once centre is reached.
                    if (duty_q == D_CTR) begin
                        state_d = OFF;
                        dir_d   = 1'b1;
                    end else begin
                        duty_d = (duty_q > D_CTR) ? duty_dec : duty_inc;
                        if (duty_d == D_CTR) begin
                            state_d = OFF;
                            dir_d   = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= OFF;
            duty_q   <= D_CTR;
            shadow_q <= D_CTR;
            dir_q    <= 1'b1;
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            shadow_q <= shadow_d;
            dir_q    <= dir_d;
            pwm_q    <= pwm_d;
        end
    end

    assign duty = duty_q;
    assign busy = (state_q != OFF);
    assign pwm  = pwm_q;

endmodule

// File: rtl/servo_sweep_multi.sv
// rtl/servo_sweep_multi.sv - multi-channel servo sweep controller with shared step tick and PWM phase
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   start_stop/home/rot_toggle  per-channel one-cycle control pulses
//   rot_en                   per-channel step enable level
//   duty_out                 working duties, channel k at [k*N +: N]
//   busy                     per-channel SWEEP/HOMING indicator
//   frame_start              one-cycle pulse as the phase wraps to 0
//   motor_pwm                per-channel registered PWM
module servo_sweep_multi
    import servo_pkg::*;
#(
    parameter int SYS_FREQ = 125,
    parameter int N        = 12,
    parameter int CH       = 2,
    parameter int STEP_MS  = 4,
    parameter int DUTY_MIN = 113,
    parameter int DUTY_MAX = 521,
    parameter int DUTY_CTR = 317
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [CH-1:0]   start_stop,
    input  logic [CH-1:0]   home,
    input  logic [CH-1:0]   rot_toggle,
    input  logic [CH-1:0]   rot_en,
    output logic [CH*N-1:0] duty_out,
    output logic [CH-1:0]   busy,
    output logic            frame_start,
    output logic [CH-1:0]   motor_pwm
);

    localparam int STEP_CYC = STEP_MS * 1000 * SYS_FREQ;
    localparam int STEP_W   = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int DIV      = calc_div(SYS_FREQ, N);
    localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;

    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    logic [N-1:0]      phase_q, phase_d;
    logic              frame_start_q, frame_start_d;
    logic              step_tick, presc_wrap, frame_wrap;

    assign step_tick  = (step_cnt_q == STEP_W'(STEP_CYC - 1));
    assign presc_wrap = (presc_q == DIV_W'(DIV - 1));
    assign frame_wrap = presc_wrap && (phase_q == {N{1'b1}});

    always_comb begin
        step_cnt_d    = step_tick ? '0 : step_cnt_q + STEP_W'(1);
        presc_d       = presc_wrap ? '0 : presc_q + DIV_W'(1);
        phase_d       = presc_wrap ? phase_q + N'(1) : phase_q;
        frame_start_d = frame_wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_cnt_q    <= '0;
            presc_q       <= '0;
            phase_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            step_cnt_q    <= step_cnt_d;
            presc_q       <= presc_d;
            phase_q       <= phase_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

    for (genvar k = 0; k < CH; k++) begin : g_ch
        servo_sweep_ch #(
            .N        (N),
            .DUTY_MIN (DUTY_MIN),
            .DUTY_MAX (DUTY_MAX),
            .DUTY_CTR (DUTY_CTR)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .start_stop (start_stop[k]),
            .home       (home[k]),
            .rot_toggle (rot_toggle[k]),
            .rot_en     (rot_en[k]),
            .step_tick  (step_tick),
            .frame_load (frame_wrap),
            .phase      (phase_q),
            .duty       (duty_out[k*N +: N]),
            .busy       (busy[k]),
            .pwm        (motor_pwm[k])
        );
    end

endmodule

// File: tb/tb_servo_sweep_multi.sv
// tb/tb_servo_sweep_multi.sv - scoreboard bench for servo_sweep_multi against an edge-count reference model
module tb_servo_sweep_multi;

    localparam int SYS_FREQ = 1;
    localparam int N        = 12;
    localparam int CH       = 2;
    localparam int STEP_MS  = 1;
    localparam int DUTY_MIN = 4;
    localparam int DUTY_MAX = 12;
    localparam int DUTY_CTR = 8;

    localparam int P   = STEP_MS * 1000 * SYS_FREQ;      // clocks per sweep step
    localparam int DIV = (SYS_FREQ * 1000000) / (50 * (1 << N));
    localparam int F   = DIV * (1 << N);                 // clocks per frame

    localparam int MODE_OFF = 0, MODE_SWEEP = 1, MODE_HOME = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [CH-1:0]   start_stop, home, rot_toggle, rot_en;
    logic [CH*N-1:0] duty_out;
    logic [CH-1:0]   busy, motor_pwm;
    logic            frame_start;

    servo_sweep_multi #(
        .SYS_FREQ (SYS_FREQ), .N (N), .CH (CH), .STEP_MS (STEP_MS),
        .DUTY_MIN (DUTY_MIN), .DUTY_MAX (DUTY_MAX), .DUTY_CTR (DUTY_CTR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_stop  (start_stop),
        .home        (home),
        .rot_toggle  (rot_toggle),
        .rot_en      (rot_en),
        .duty_out    (duty_out),
        .busy        (busy),
        .frame_start (frame_start),
        .motor_pwm   (motor_pwm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH*N-1:0] duty;
        logic [CH-1:0]   busy;
        logic [CH-1:0]   pwm;
        logic            fs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: plain integers advanced by edge count.
    int mode_m[CH];
    int duty_m[CH];
    int dir_m[CH];
    int shadow_m[CH];
    int phase_m;
    int e;

    task automatic model_reset();
        for (int k = 0; k < CH; k++) begin
            mode_m[k]   = MODE_OFF;
            duty_m[k]   = DUTY_CTR;
            dir_m[k]    = 1;
            shadow_m[k] = DUTY_CTR;
        end
        phase_m = 0;
        e       = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        exp_t x;
        bit   tick;
        x.pwm = '0;
        x.fs  = 1'b0;
        if (!reset_n) begin
            model_reset();
        end else begin
            e++;
            for (int k = 0; k < CH; k++) x.pwm[k] = (phase_m < shadow_m[k]);
            x.fs = (e % F == 0);
            if (x.fs) for (int k = 0; k < CH; k++) shadow_m[k] = duty_m[k];
            phase_m = (e / DIV) % (1 << N);
            tick = (e % P == 0);
            for (int k = 0; k < CH; k++) begin
                if (start_stop[k]) begin
                    mode_m[k] = (mode_m[k] == MODE_OFF) ? MODE_SWEEP : MODE_OFF;
                end else if (home[k]) begin
                    mode_m[k] = MODE_HOME;
                end else if (rot_toggle[k]) begin
                    dir_m[k] = 1 - dir_m[k];
                end else if (tick && rot_en[k]) begin
                    if (mode_m[k] == MODE_SWEEP) begin
                        duty_m[k] += dir_m[k] ? 1 : -1;
                        if (duty_m[k] >= DUTY_MAX) begin duty_m[k] = DUTY_MAX; dir_m[k] = 0; end
                        if (duty_m[k] <= DUTY_MIN) begin duty_m[k] = DUTY_MIN; dir_m[k] = 1; end
                    end else if (mode_m[k] == MODE_HOME) begin
                        if (duty_m[k] > DUTY_CTR) duty_m[k]--;
                        else if (duty_m[k] < DUTY_CTR) duty_m[k]++;
                        if (duty_m[k] == DUTY_CTR) begin mode_m[k] = MODE_OFF; dir_m[k] = 1; end
                    end
                end
            end
        end
        for (int k = 0; k < CH; k++) begin
            x.duty[k*N +: N] = N'(duty_m[k]);
            x.busy[k]        = (mode_m[k] != MODE_OFF);
        end
        exp_q.push_back(x);
    end

    // Monitor: one expectation per edge, compared half a cycle later.
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checks += 4;
            if (duty_out !== x.duty) begin
                errors++;
                $display("FAIL duty_out t=%0t got %h want %h", $time, duty_out, x.duty);
            end
            if (busy !== x.busy) begin
                errors++;
                $display("FAIL busy t=%0t got %b want %b", $time, busy, x.busy);
            end
            if (motor_pwm !== x.pwm) begin
                errors++;
                $display("FAIL motor_pwm t=%0t got %b want %b", $time, motor_pwm, x.pwm);
            end
            if (frame_start !== x.fs) begin
                errors++;
                $display("FAIL frame_start t=%0t got %b want %b", $time, frame_start, x.fs);
            end
        end
    end

    task automatic check_reset_now(input string tag);
        logic [CH*N-1:0] want_duty;
        for (int k = 0; k < CH; k++) want_duty[k*N +: N] = N'(DUTY_CTR);
        checks += 4;
        if (duty_out !== want_duty) begin errors++; $display("FAIL %s duty_out got %h want %h", tag, duty_out, want_duty); end
        if (busy !== '0) begin errors++; $display("FAIL %s busy got %b want 0", tag, busy); end
        if (motor_pwm !== '0) begin errors++; $display("FAIL %s motor_pwm got %b want 0", tag, motor_pwm); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL %s frame_start got %b want 0", tag, frame_start); end
    endtask

    // Called at a falling edge; holds the pulse for exactly one rising edge.
    task automatic pulse(input int which, input int k);
        case (which)
            0: start_stop[k] = 1'b1;
            1: home[k]       = 1'b1;
            default: rot_toggle[k] = 1'b1;
        endcase
        @(negedge clk);
        start_stop = '0;
        home       = '0;
        rot_toggle = '0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        start_stop = '0;
        home       = '0;
        rot_toggle = '0;
        rot_en     = '0;
        wait_cycles(3);
        check_reset_now("reset");
        reset_n = 1'b1;
        rot_en  = '1;

        // Channel 0 sweeps up to the left limit, back down to the right limit and beyond.
        pulse(0, 0);
        wait_cycles(14 * P);

        // Home while already centred: leaves HOMING on the next tick.
        pulse(1, 1);
        wait_cycles(2 * P);

        // Channel 1 climbs off centre then homes back down.
        pulse(0, 1);
        wait_cycles(3 * P);
        pulse(1, 1);
        wait_cycles(5 * P);

        // start_stop wins over a simultaneous rot_toggle.
        start_stop[0] = 1'b1;
        rot_toggle[0] = 1'b1;
        @(negedge clk);
        start_stop = '0;
        rot_toggle = '0;
        wait_cycles(2 * P);
        pulse(0, 0);
        wait_cycles(P);

        // Frozen steps while rot_en is low.
        rot_en[0] = 1'b0;
        wait_cycles(2 * P);
        rot_en[0] = 1'b1;
        wait_cycles(P);

        // Randomized control traffic.
        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, 1999) == 0) rot_en = CH'($urandom_range(0, (1 << CH) - 1));
            if ($urandom_range(0, 399) == 0)
                pulse(int'($urandom_range(0, 2)), int'($urandom_range(0, CH - 1)));
            else
                @(negedge clk);
        end

        // Asynchronous reset in the middle of a sweep.
        rot_en = '1;
        if (mode_m[0] != MODE_SWEEP) begin
            if (mode_m[0] == MODE_HOME) pulse(0, 0);
            pulse(0, 0);
        end
        wait_cycles(2 * P + 345);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_now("async_reset");
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(3 * P);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_sweep_multi.md
# servo_sweep_multi

Parametrised multi-channel servo sweep controller, the successor to our single-channel oscillating fan servo driver. Each of `CH` channels drives one hobby servo with a 50 Hz PWM frame and independently sweeps its duty between programmable limits, with start/stop, forced reversal, and a new return-to-centre (home) mode. All channels share one step-tick generator and one PWM phase counter. Duty updates are latched at frame boundaries so no channel emits a runt pulse.

## Interface
Parameters:
- `SYS_FREQ`, 125: system clock in MHz.
- `N`, 12: duty/phase width in bits.
- `CH`, 2: channel count, 1..8.
- `STEP_MS`, 4: milliseconds per one-LSB sweep step.
- `DUTY_MIN`, 113: right limit, in N-bit duty units.
- `DUTY_MAX`, 521: left limit.
- `DUTY_CTR`, 317: centre; must satisfy `DUTY_MIN < DUTY_CTR < DUTY_MAX < 2^N`.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start_stop`  in  CH  one-cycle pulse per channel; toggles the channel between OFF and SWEEP.
- `home`  in  CH  one-cycle pulse; starts HOMING.
- `rot_toggle`  in  CH  one-cycle pulse; inverts direction.
- `rot_en`  in  CH  level; when low, steps are frozen and state is held.
- `duty_out`  out  CH*N  current working duty; channel k occupies bits [k*N +: N].
- `busy`  out  CH  high while in SWEEP or HOMING.
- `frame_start`  out  1  one-cycle pulse at each PWM frame boundary.
- `motor_pwm`  out  CH  registered PWM outputs.

## Operation
- Per-channel FSM with states OFF, SWEEP, HOMING. Reset state is OFF, working duty = `DUTY_CTR`, `dir` = 1 (increasing, left first).
- Input priority within a channel for a given cycle: `start_stop` > `home` > `rot_toggle` > step tick. Only the highest-priority event is acted on.
- `start_stop`: OFF→SWEEP; SWEEP→OFF; HOMING→OFF.
- `home`: SWEEP or OFF→HOMING. It is ignored when the channel is already in HOMING.
- `rot_toggle`: inverts `dir` in any state. In HOMING the direction is recomputed each step, so the toggle has no visible effect there.
- Step tick, when the channel is SWEEP and `rot_en` is high:
  - duty ← duty + 1 if `dir`, otherwise duty − 1.
  - If the new duty equals `DUTY_MAX`, `dir` ← 0. If it equals `DUTY_MIN`, `dir` ← 1.
  - If duty is already at or beyond a limit in the outward direction, it clamps to the limit and `dir` flips. Duty never leaves [`DUTY_MIN`, `DUTY_MAX`].
- Step tick, when the channel is HOMING and `rot_en` is high:
  - duty moves one LSB toward `DUTY_CTR`.
  - When duty equals `DUTY_CTR`, the state goes to OFF with `dir` = 1. This includes the case where `home` arrives while duty is already at centre: the channel enters OFF on the next tick.
- Step tick: a shared counter pulses once every `STEP_MS`*1000*`SYS_FREQ` clocks (500 000 at defaults).
- PWM:
  - A shared prescaler divides by `DIV` = floor(`SYS_FREQ`*10^6 / (50*2^N)), which is 610 at defaults.
  - An N-bit phase counter advances once per prescaler wrap. `frame_start` pulses when the phase wraps from 2^N−1 to 0.
  - Each channel holds a shadow duty, loaded from the working duty on `frame_start`.
  - `motor_pwm[k]` is high when phase < shadow[k].

## Timing
- Reset values: `motor_pwm` = 0, `busy` = 0, `frame_start` = 0, every `duty_out` slice = `DUTY_CTR`. Every shadow register = `DUTY_CTR`. The prescaler, phase counter and step counter are all 0.
- Control pulses take effect on the clock edge where they are sampled. `busy` and the state register update in that same edge, and are visible the next cycle.
- `duty_out` changes on the clock edge after the step-tick pulse.
- A `duty_out` change reaches `motor_pwm` only from the next `frame_start`. This gives a worst-case latency of 1 frame (2^N*`DIV` clocks = 2 498 560 at defaults).
- `motor_pwm` is registered: it reflects phase and shadow with one clock of latency.
- Shadow = 0 gives a constant low output. Shadow values cannot reach 2^N, because duty is capped at `DUTY_MAX`.
- Asserting `reset_n` mid-frame or mid-sweep forces all reset values immediately, asynchronously. Counting resumes from 0 on the first edge after deassertion.

## Structure
- Shared package `servo_pkg`:
  - state enum `servo_state_t` {OFF, SWEEP, HOMING}.
  - the PWM base frequency constant (50 Hz).
  - a function computing `DIV` from `SYS_FREQ` and N.
- One sub-module, `servo_sweep_ch`: it holds the per-channel FSM, working duty, `dir`, shadow register and comparator, and is instantiated `CH` times with a generate loop.
- The top level holds the step counter, prescaler, phase counter and output packing.

## Test plan
- Reset release, then pulse `start_stop[0]` with `rot_en` = 1 → `busy[0]` = 1 and duty rises 317→318 after the first tick. It reaches 521 after 204 ticks, then 520 on the next tick. Channel 1 stays at 317.
- Sweep to `DUTY_MIN` → the sequence 114, 113, 114 appears across three consecutive ticks, with no value below 113.
- At duty 400 in SWEEP, pulse `home[1]` → duty steps down 399…317, one LSB per tick. At 317 the state is OFF, `busy[1]` = 0 and `dir` = 1.
- `start_stop` and `rot_toggle` asserted in the same cycle → only the state toggles; `dir` is unchanged.
- Duty changes mid-frame → `motor_pwm` high width stays unchanged until the next `frame_start`. After it, the width equals new duty × `DIV` clocks, ±1 clock.
- Assert `reset_n` low mid-sweep at duty 450 → all outputs take their reset values within the same cycle. After release, `duty_out` = 317 and the channel is in OFF.
